// File: rtl/sr_result_voter.sv
// sr_result_voter: windowed majority vote of frame classes plus truncated mean of regression results.
// Optional SR_VOTE_CONF_EN: majorities below THRESH are reported as class 4'hF.
module sr_result_voter #(
   parameter int WIN    = 8,
   parameter int THRESH = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [3:0]  in_class,
   input  logic [23:0] in_regres,
   input  logic        clear,
   output logic        vote_valid,
   output logic [3:0]  vote_class,
   output logic [4:0]  vote_count,
   output logic [23:0] mean_regres,
   output logic [4:0]  frame_cnt,
   output logic        overflow
);
   localparam int LW = $clog2(WIN);
   localparam int SW = 24 + LW;

   typedef enum logic [1:0] {COLLECT, SCAN, EMIT} state_t;

   state_t      state, state_nx;
   logic [4:0]  hist [16];
   logic [SW-1:0] sum;
   logic        pend_v, pend_nx, store_new, drop;
   logic [3:0]  pend_cls;
   logic [23:0] pend_reg;
   logic [3:0]  idx, max_cls;
   logic [4:0]  max_cnt;
   logic        acc, last;
   logic [3:0]  acc_cls;
   logic [23:0] acc_reg;

   always_comb begin
      acc       = state == COLLECT && (pend_v || in_valid);
      acc_cls   = pend_v ? pend_cls : in_class;
      acc_reg   = pend_v ? pend_reg : in_regres;
      last      = acc && frame_cnt == 5'(WIN - 1);
      // A pending entry is drained on a COLLECT cycle, so a new result refills it only then.
      store_new = in_valid && (state == COLLECT ? pend_v : !pend_v);
      drop      = in_valid && state != COLLECT && pend_v;
      pend_nx   = state == COLLECT ? (in_valid && pend_v) : (pend_v || in_valid);
      state_nx  = state;
      if (clear)
         state_nx = COLLECT;
      else if (state == COLLECT)
         state_nx = last ? SCAN : COLLECT;
      else if (state == SCAN)
         state_nx = idx == 4'd15 ? EMIT : SCAN;
      else
         state_nx = COLLECT;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= COLLECT;
         for (int i = 0; i < 16; i++) hist[i] <= '0;
         sum         <= '0;
         pend_v      <= 1'b0;
         pend_cls    <= '0;
         pend_reg    <= '0;
         idx         <= '0;
         max_cls     <= '0;
         max_cnt     <= '0;
         frame_cnt   <= '0;
         vote_valid  <= 1'b0;
         vote_class  <= '0;
         vote_count  <= '0;
         mean_regres <= '0;
         overflow    <= 1'b0;
      end else begin
         state      <= state_nx;
         vote_valid <= 1'b0;
         if (clear) begin
            for (int i = 0; i < 16; i++) hist[i] <= '0;
            sum       <= '0;
            frame_cnt <= '0;
            pend_v    <= 1'b0;
         end else begin
            if (drop) overflow <= 1'b1;
            pend_v <= pend_nx;
            if (store_new) begin
               pend_cls <= in_class;
               pend_reg <= in_regres;
            end
            if (state == EMIT) begin
               vote_valid  <= 1'b1;
`ifdef SR_VOTE_CONF_EN
               vote_class  <= max_cnt < 5'(THRESH) ? 4'hF : max_cls;
`else
               vote_class  <= max_cls;
`endif
               vote_count  <= max_cnt;
               mean_regres <= 24'(sum >> LW);
               for (int i = 0; i < 16; i++) hist[i] <= '0;
               sum         <= '0;
               frame_cnt   <= '0;
            end else if (acc) begin
               hist[acc_cls] <= hist[acc_cls] + 5'd1;
               sum           <= sum + SW'(acc_reg);
               frame_cnt     <= frame_cnt + 5'd1;
               if (last) begin
                  idx     <= '0;
                  max_cnt <= '0;
                  max_cls <= '0;
               end
            end
            // Strictly-greater update keeps the lowest class index on ties.
            if (state == SCAN) begin
               idx <= idx + 4'd1;
               if (hist[idx] > max_cnt) begin
                  max_cnt <= hist[idx];
                  max_cls <= idx;
               end
            end
         end
      end
   end
endmodule
